cond_handler: RTL

- Downstream consumer of the ALU/PSR flag stage.
- Evaluates the 4-bit ARM condition field of the instruction in EX against the current flags. The flags come from the PSR, or are forwarded from the ALU when the PSR is being loaded in the same cycle.
- Produces registered execute-enable, branch-taken and link-write strobes.
- Runs a flush counter that squashes younger pipeline stages after a taken branch.

---
 rtl/cond_handler_pkg.sv | 32 +++
 rtl/cond_handler_eval.sv | 39 +++
 rtl/cond_handler.sv | 101 ++++++++++
 3 files changed

// File: rtl/cond_handler_pkg.sv
// Shared definitions for ARM condition evaluation: condition codes, FSM states, flag order.
package cond_handler_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Flag vector bit positions: {N, Z, C, V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/cond_handler_eval.sv
// Combinational ARM condition-field evaluator: cond[3:0] against flags {N,Z,C,V} -> pass.
module cond_eval
  import cond_handler_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_handler.sv
// Registered conditional-execute / branch / link strobes, plus a flush counter that
// squashes younger stages for FLUSH_CYCLES cycles after a taken branch.
module cond_handler
  import cond_handler_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       valid,
  input  logic [3:0] cond,
  input  logic       is_branch,
  input  logic       is_link,
  input  logic       N,
  input  logic       Zero,
  input  logic       C,
  input  logic       V,
  input  logic       N_,
  input  logic       Zero_,
  input  logic       C_,
  input  logic       V_,
  input  logic       psr_load,
  output logic       cond_pass,
  output logic       branch_taken,
  output logic       link_we,
  output logic       flush,
  output logic       busy
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       cp_n, bt_n, lw_n, fl_n, busy_n;
  logic [3:0] eff_flags;
  logic       pass;

  // The PSR is being rewritten this cycle, so the ALU flags are the architecturally current ones.
  assign eff_flags = psr_load ? {N_, Zero_, C_, V_} : {N, Zero, C, V};

  cond_eval u_eval (
    .cond  (cond),
    .flags (eff_flags),
    .pass  (pass)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cp_n    = 1'b0;
    bt_n    = 1'b0;
    lw_n    = 1'b0;
    fl_n    = 1'b0;
    busy_n  = 1'b0;
    case (state)
      IDLE: begin
        cp_n = valid & pass;
        if (valid & pass & is_branch) begin
          bt_n    = 1'b1;
          lw_n    = is_link;
          fl_n    = 1'b1;
          busy_n  = 1'b1;
          cnt_n   = FLUSH_INIT;
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt == 4'd1) begin
          cnt_n   = 4'd0;
          state_n = IDLE;
        end else begin
          cnt_n  = cnt - 4'd1;
          fl_n   = 1'b1;
          busy_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      cond_pass    <= 1'b0;
      branch_taken <= 1'b0;
      link_we      <= 1'b0;
      flush        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      cond_pass    <= cp_n;
      branch_taken <= bt_n;
      link_we      <= lw_n;
      flush        <= fl_n;
      busy         <= busy_n;
    end
  end

endmodule
